// File: rtl/soc_video_bridge_if.sv
// Bus bundle between the picorv32-side decode and the soc_video register port.
// The bridge takes the slave view; the CPU/video side takes the master view.
interface soc_video_bridge_if;
  logic        cpu_sel;
  logic [3:0]  cpu_wstrb;
  logic [23:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;

  logic        vid_sel;
  logic [3:0]  vid_wren;
  logic [23:0] vid_address;
  logic [31:0] vid_data_in;
  logic [31:0] vid_data_out;
  logic        vid_hold;

  modport master (
    output cpu_sel, cpu_wstrb, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata,
    input  vid_sel, vid_wren, vid_address, vid_data_in,
    output vid_data_out, vid_hold
  );

  modport slave (
    input  cpu_sel, cpu_wstrb, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata,
    output vid_sel, vid_wren, vid_address, vid_data_in,
    input  vid_data_out, vid_hold
  );
endinterface

// File: rtl/soc_video_bridge.sv
// Posted-write / serialised-read adapter from the picorv32 native bus to soc_video.
// Writes queue in a FIFO; reads wait for the FIFO to drain, then issue and return data.
module soc_video_bridge #(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                        clk_cpu,
  input  logic                        n_reset,
  soc_video_bridge_if.slave           bus,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {IDLE, R_DRAIN, R_ISSUE, R_WAIT} state_t;

  typedef struct packed {
    logic [23:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } entry_t;

  state_t             state_q, state_d;
  entry_t             mem [FIFO_DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level_q;
  logic [LAT_W-1:0]   lat_q;
  logic [23:0]        rd_addr_q;

  logic push, pop, accept_rd, issue_rd, capture, full;

  assign full       = (level_q == LVL_W'(FIFO_DEPTH));
  assign head       = mem[rd_ptr];
  assign fifo_level = level_q;
  assign busy       = (level_q != '0) || (state_q != IDLE);

  // NOTE: every signal is given a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    accept_rd = 1'b0;
    issue_rd  = 1'b0;
    capture   = 1'b0;
    // Reads only issue once the FIFO is empty, so draining never competes with them.
    pop       = (level_q != '0) && !bus.vid_hold;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_sel && !bus.cpu_ready) begin
          if (bus.cpu_wstrb != 4'b0000) begin
            push = !full;
          end else begin
            accept_rd = 1'b1;
            state_d   = R_DRAIN;
          end
        end
      end
      R_DRAIN: begin
        if (level_q == '0) state_d = R_ISSUE;
      end
      R_ISSUE: begin
        if (!bus.vid_hold) begin
          issue_rd = 1'b1;
          state_d  = R_WAIT;
        end
      end
      R_WAIT: begin
        if (lat_q == LAT_W'(READ_LATENCY)) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: the FIFO storage has no reset; the pointers and level define which
  // entries are valid, so clearing them alone discards the contents.
  always_ff @(posedge clk_cpu) begin
    if (push) mem[wr_ptr] <= '{addr: bus.cpu_addr, strb: bus.cpu_wstrb, data: bus.cpu_wdata};
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level_q         <= '0;
      lat_q           <= '0;
      rd_addr_q       <= '0;
      bus.cpu_ready   <= 1'b0;
      bus.cpu_rdata   <= '0;
      bus.vid_sel     <= 1'b0;
      bus.vid_wren    <= '0;
      bus.vid_address <= '0;
      bus.vid_data_in <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase

      if (accept_rd) rd_addr_q <= bus.cpu_addr;

      // Latency is counted from the cycle the read strobe is actually on the bus.
      if (issue_rd)               lat_q <= '0;
      else if (state_q == R_WAIT) lat_q <= lat_q + 1'b1;

      bus.cpu_ready <= push | capture;
      if (capture) bus.cpu_rdata <= bus.vid_data_out;

      bus.vid_sel  <= pop | issue_rd;
      bus.vid_wren <= pop ? head.strb : 4'b0000;
      if (pop) begin
        bus.vid_address <= head.addr;
        bus.vid_data_in <= head.data;
      end else if (issue_rd) begin
        bus.vid_address <= rd_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_soc_video_bridge.sv
// Directed bench for soc_video_bridge: table of single writes plus hand-written
// sequences for backpressure, read ordering, read latency and reset.
module tb_soc_video_bridge;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       busy, busy3;
  logic [2:0] level, level3;

  soc_video_bridge_if bus ();
  soc_video_bridge_if bus3 ();

  soc_video_bridge #(.FIFO_DEPTH(4), .READ_LATENCY(1)) dut (
    .clk_cpu(clk), .n_reset(n_reset), .bus(bus), .busy(busy), .fifo_level(level)
  );

  soc_video_bridge #(.FIFO_DEPTH(4), .READ_LATENCY(3)) dut3 (
    .clk_cpu(clk), .n_reset(n_reset), .bus(bus3), .busy(busy3), .fifo_level(level3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  wren;
    logic [23:0] addr;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    logic [23:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [3:0]  exp_wren;
    logic [23:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t log_q[$];

  // Cycle counter and vid-side event log, sampled shortly after each rising edge.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #2;
    if (bus.vid_sel) log_q.push_back('{cyc, bus.vid_wren, bus.vid_address, bus.vid_data_in});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [23:0] a, input logic [3:0] s, input logic [31:0] d);
    int n;
    bus.cpu_addr  = a;
    bus.cpu_wstrb = s;
    bus.cpu_wdata = d;
    bus.cpu_sel   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.cpu_ready && n < 10);
    check("write_ready", bus.cpu_ready, 1'b1);
    bus.cpu_sel = 1'b0;
  endtask

  initial begin
    vec_t vecs[4];
    int   a, t, r, ts, tr, phase, n_sel, pops5, n_wr;
    bit   got, any_sel;
    logic [31:0] rd;

    vecs[0] = '{24'he00001, 4'b0010, 32'h22222222, 4'b0010, 24'he00001, 32'h22222222};
    vecs[1] = '{24'h000000, 4'b1111, 32'h00000000, 4'b1111, 24'h000000, 32'h00000000};
    vecs[2] = '{24'hffffff, 4'b1000, 32'ha5a5a5a5, 4'b1000, 24'hffffff, 32'ha5a5a5a5};
    vecs[3] = '{24'h123456, 4'b0101, 32'h00ff00ff, 4'b0101, 24'h123456, 32'h00ff00ff};

    // Reset held with a live request on the bus.
    n_reset           = 1'b0;
    bus.cpu_sel       = 1'b1;
    bus.cpu_wstrb     = 4'hf;
    bus.cpu_addr      = 24'he00001;
    bus.cpu_wdata     = 32'h12345678;
    bus.vid_hold      = 1'b0;
    bus.vid_data_out  = 32'hdeadbeef;
    bus3.cpu_sel      = 1'b0;
    bus3.cpu_wstrb    = 4'h0;
    bus3.cpu_addr     = 24'h0;
    bus3.cpu_wdata    = 32'h0;
    bus3.vid_hold     = 1'b0;
    bus3.vid_data_out = 32'hdeadbeef;
    repeat (3) tick();
    check("rst_cpu_ready", bus.cpu_ready, 1'b0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_vid_sel", bus.vid_sel, 1'b0);
    check("rst_vid_wren", bus.vid_wren, 4'h0);
    check("rst_vid_address", bus.vid_address, 24'h0);
    check("rst_vid_data_in", bus.vid_data_in, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_level", level, 3'd0);
    bus.cpu_sel = 1'b0;
    n_reset     = 1'b1;
    any_sel     = 1'b0;
    repeat (5) begin
      tick();
      any_sel |= bus.vid_sel | bus3.vid_sel;
    end
    check("idle_no_vid_sel", any_sel, 1'b0);

    // Single writes from the vector table.
    for (int i = 0; i < 4; i++) begin
      bus.cpu_addr  = vecs[i].addr;
      bus.cpu_wstrb = vecs[i].wstrb;
      bus.cpu_wdata = vecs[i].wdata;
      bus.cpu_sel   = 1'b1;
      tick();
      check("vec_ready", bus.cpu_ready, 1'b1);
      bus.cpu_sel = 1'b0;
      tick();
      check("vec_vid_sel", bus.vid_sel, 1'b1);
      check("vec_vid_wren", bus.vid_wren, vecs[i].exp_wren);
      check("vec_vid_address", bus.vid_address, vecs[i].exp_addr);
      check("vec_vid_data_in", bus.vid_data_in, vecs[i].exp_data);
      tick();
      check("vec_vid_sel_off", bus.vid_sel, 1'b0);
    end

    // Backpressure: fill the FIFO, stall the fifth write, then drain.
    bus.vid_hold = 1'b1;
    for (int i = 0; i < 4; i++) do_write(24'hf00000 + 24'(i), 4'hf, 32'(i));
    check("full_level", level, 3'd4);
    check("full_busy", busy, 1'b1);
    bus.cpu_addr  = 24'hf00004;
    bus.cpu_wstrb = 4'hf;
    bus.cpu_wdata = 32'd4;
    bus.cpu_sel   = 1'b1;
    any_sel = 1'b0;
    got     = 1'b0;
    repeat (3) begin
      tick();
      got     |= bus.cpu_ready;
      any_sel |= bus.vid_sel;
    end
    check("full_stall_ready", got, 1'b0);
    check("full_hold_no_sel", any_sel, 1'b0);
    bus.vid_hold = 1'b0;
    log_q.delete();
    phase = 0;
    n_sel = 0;
    pops5 = -1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.vid_sel) n_sel++;
      case (phase)
        0: if (bus.cpu_ready) begin pops5 = n_sel; bus.cpu_sel = 1'b0; phase = 1; end
        1: begin
          bus.cpu_addr  = 24'hf00005;
          bus.cpu_wdata = 32'd5;
          bus.cpu_sel   = 1'b1;
          phase = 2;
        end
        2: if (bus.cpu_ready) begin bus.cpu_sel = 1'b0; phase = 3; end
        default: ;
      endcase
    end
    check("full_writes_done", phase, 3);
    check("full_ready5_after_pop", pops5, 2);
    check("full_issue_count", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      check("full_order_addr", log_q[i].addr, 24'hf00000 + 24'(i));
      check("full_order_data", log_q[i].data, 32'(i));
      check("full_order_wren", log_q[i].wren, 4'hf);
    end
    check("drained_level", level, 3'd0);
    check("drained_busy", busy, 1'b0);

    // Read behind two posted writes, READ_LATENCY=1.
    log_q.delete();
    do_write(24'he00010, 4'hf, 32'h11111111);
    do_write(24'he00014, 4'h3, 32'h22222222);
    bus.cpu_addr  = 24'he00000;
    bus.cpu_wstrb = 4'h0;
    bus.cpu_sel   = 1'b1;
    got = 1'b0; t = -100; r = -1; rd = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!got && bus.vid_sel && bus.vid_wren == 4'h0) begin got = 1'b1; t = cyc; end
      if (bus.cpu_ready) begin r = cyc; rd = bus.cpu_rdata; bus.cpu_sel = 1'b0; break; end
      if (got && cyc == t + 1) bus.vid_data_out = 32'h44332211;
      else                     bus.vid_data_out = 32'hdeadbeef;
    end
    bus.vid_data_out = 32'hdeadbeef;
    check("rd1_issued", got, 1'b1);
    check("rd1_ready_cycle", r - t, 2);
    check("rd1_rdata", rd, 32'h44332211);
    n_wr = 0;
    foreach (log_q[i]) if (log_q[i].wren != 4'h0 && log_q[i].cyc < t) n_wr++;
    check("rd1_after_writes", n_wr, 2);
    check("rd1_log_size", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("rd1_w0_addr", log_q[0].addr, 24'he00010);
      check("rd1_w1_addr", log_q[1].addr, 24'he00014);
      check("rd1_r_addr", log_q[2].addr, 24'he00000);
    end

    // Same read against the READ_LATENCY=3 instance.
    bus3.cpu_addr = 24'he00004;
    bus3.cpu_sel  = 1'b1;
    got = 1'b0; t = -100; r = -1; rd = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!got && bus3.vid_sel) begin
        got = 1'b1;
        t   = cyc;
        check("rd3_wren", bus3.vid_wren, 4'h0);
        check("rd3_addr", bus3.vid_address, 24'he00004);
      end
      if (bus3.cpu_ready) begin r = cyc; rd = bus3.cpu_rdata; bus3.cpu_sel = 1'b0; break; end
      if (got && cyc == t + 3) bus3.vid_data_out = 32'h55667788;
      else                     bus3.vid_data_out = 32'hdeadbeef;
    end
    bus3.vid_data_out = 32'hdeadbeef;
    check("rd3_ready_cycle", r - t, 4);
    check("rd3_rdata", rd, 32'h55667788);

    // Hold asserted for three cycles while the read is in R_ISSUE.
    bus.vid_hold  = 1'b1;
    bus.cpu_addr  = 24'he00008;
    bus.cpu_wstrb = 4'h0;
    bus.cpu_sel   = 1'b1;
    a = cyc;
    ts = -1; tr = -1; rd = '0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (ts < 0 && bus.vid_sel) ts = cyc - a;
      if (bus.cpu_ready) begin tr = cyc - a; rd = bus.cpu_rdata; bus.cpu_sel = 1'b0; break; end
      if (cyc - a == 5) bus.vid_hold = 1'b0;
    end
    check("hold_rd_issue_cycle", ts, 6);
    check("hold_rd_ready_cycle", tr, 8);
    check("hold_rd_rdata", rd, 32'hdeadbeef);

    // Reset with three writes still queued.
    tick();
    bus.vid_hold = 1'b1;
    for (int i = 0; i < 3; i++) do_write(24'ha00000 + 24'(i), 4'hf, 32'hc0de0000 + 32'(i));
    check("mid_level_before", level, 3'd3);
    n_reset = 1'b0;
    #1;
    check("mid_rst_level", level, 3'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", bus.cpu_ready, 1'b0);
    check("mid_rst_vid_sel", bus.vid_sel, 1'b0);
    repeat (2) tick();
    n_reset      = 1'b1;
    bus.vid_hold = 1'b0;
    any_sel      = 1'b0;
    repeat (5) begin
      tick();
      any_sel |= bus.vid_sel;
    end
    check("mid_no_stale_sel", any_sel, 1'b0);
    check("mid_level_after", level, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
